mux2_stream_arbiter: RTL and testbench

Round-robin arbiter that shares one 2:1 mux datapath between two valid/ready requester streams and drives the mux select. It grants whole packets (delimited by a last flag), registers the selected beat into a single-entry output stage, and exposes the select of the beat currently held. It sits directly in front of the downstream consumer of the shared mux output.

---
 rtl/mux2_stream_arbiter.sv | 146 ++++++++++++++
 tb/tb_mux2_stream_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mux2_stream_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux2_stream_arbiter
//  Description : Packet-granular round-robin arbiter for two valid/ready
//                streams that share one 2:1 mux. It drives the mux select and
//                registers the selected beat into a single-entry output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux2_stream_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             sel,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOCK0 = 2'd1,
        S_LOCK1 = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ptr;
    logic             w_ptr_nxt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic             r_sel;

    logic             w_slot_free;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_xfer0;
    logic             w_xfer1;

    // The output register can take a beat when empty or being drained now.
    assign w_slot_free = !r_out_valid | out_ready;

    // Grant selection: open round-robin contention in IDLE, fixed owner while locked.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            S_IDLE: begin
                // r_ptr holds the last winner, so the other input wins a tie.
                w_gnt0 = in0_valid & (!in1_valid | r_ptr);
                w_gnt1 = in1_valid & (!in0_valid | !r_ptr);
            end
            S_LOCK0: w_gnt0 = 1'b1;
            S_LOCK1: w_gnt1 = 1'b1;
            default: ;
        endcase
    end

    // rst_n gates the readies so nothing is accepted while reset is held.
    assign in0_ready = rst_n & w_gnt0 & w_slot_free;
    assign in1_ready = rst_n & w_gnt1 & w_slot_free;
    assign w_xfer0   = in0_valid & in0_ready;
    assign w_xfer1   = in1_valid & in1_ready;

    // Packet tracking: lock on a non-last beat, release and move the pointer on the last.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_xfer0) begin
                    if (in0_last) w_ptr_nxt   = 1'b0;
                    else          w_state_nxt = S_LOCK0;
                end else if (w_xfer1) begin
                    if (in1_last) w_ptr_nxt   = 1'b1;
                    else          w_state_nxt = S_LOCK1;
                end
            end
            S_LOCK0: begin
                if (w_xfer0 && in0_last) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = 1'b0;
                end
            end
            S_LOCK1: begin
                if (w_xfer1 && in1_last) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and priority pointer registers; pointer resets to 1 so in0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Output stage: a load beats a drain; payload and select hold once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_sel       <= 1'b0;
        end else if (w_xfer0) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in0_data;
            r_out_last  <= in0_last;
            r_sel       <= 1'b0;
        end else if (w_xfer1) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in1_data;
            r_out_last  <= in1_last;
            r_sel       <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign sel       = r_sel;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mux2_stream_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux2_stream_arbiter
//  Description : Directed self-checking bench for mux2_stream_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux2_stream_arbiter;

    logic       clk;
    logic       rst_n;
    logic       in0_valid, in0_ready, in0_last;
    logic       in1_valid, in1_ready, in1_last;
    logic [7:0] in0_data, in1_data;
    logic       out_valid, out_ready, out_last, sel, busy;
    logic [7:0] out_data;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [7:0] got_q[$];

    mux2_stream_arbiter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .sel       (sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every beat the consumer takes, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got_q.push_back(out_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       exp_sel;
        logic [7:0] exp_data;

        // ---------------- reset with both requesters active ----------------
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in0_valid = 1'b1; in0_data = 8'hA0; in0_last = 1'b1;
        in1_valid = 1'b1; in1_data = 8'hB0; in1_last = 1'b1;
        step(); step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {24'd0, out_data},  32'd0);
        chk("rst_out_last",  {31'd0, out_last},  32'd0);
        chk("rst_sel",       {31'd0, sel},       32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_readies",   {30'd0, in1_ready, in0_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("first_grant_in0", {30'd0, in1_ready, in0_ready}, 32'd1);

        // ---------------- alternation of single-beat packets ----------------
        for (int i = 0; i < 8; i++) begin
            exp_sel  = i[0];
            exp_data = (exp_sel ? 8'hB0 : 8'hA0) + 8'(i / 2);
            chk("alt_ready", {30'd0, in1_ready, in0_ready}, exp_sel ? 32'd2 : 32'd1);
            step();
            chk("alt_data", {24'd0, out_data}, {24'd0, exp_data});
            chk("alt_sel",  {31'd0, sel}, {31'd0, exp_sel});
            if (exp_sel) in1_data = in1_data + 8'd1;
            else         in0_data = in0_data + 8'd1;
        end

        // ---------------- packet lock on in0 ----------------
        in0_data = 8'h11; in0_last = 1'b0;
        in1_data = 8'hC0; in1_last = 1'b1;
        #1;
        chk("lock_ready0", {30'd0, in1_ready, in0_ready}, 32'd1);
        step();
        chk("lock_data0", {24'd0, out_data}, 32'h11);
        chk("lock_busy0", {31'd0, busy}, 32'd1);
        in0_data = 8'h12;
        #1;
        chk("lock_ready1", {30'd0, in1_ready, in0_ready}, 32'd1);
        step();
        chk("lock_data1", {24'd0, out_data}, 32'h12);
        chk("lock_busy1", {31'd0, busy}, 32'd1);
        in0_data = 8'h13; in0_last = 1'b1;
        #1;
        chk("lock_ready2", {30'd0, in1_ready, in0_ready}, 32'd1);
        step();
        chk("lock_data2", {24'd0, out_data}, 32'h13);
        chk("lock_last2", {31'd0, out_last}, 32'd1);
        chk("lock_busy2", {31'd0, busy}, 32'd0);
        in0_data = 8'h14;
        #1;
        chk("post_lock_ready", {30'd0, in1_ready, in0_ready}, 32'd2);
        step();
        chk("post_lock_data", {24'd0, out_data}, 32'hC0);
        chk("post_lock_sel",  {31'd0, sel}, 32'd1);

        // ---------------- back-pressure ----------------
        got_q.delete();
        out_ready = 1'b0;
        in1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_readies", {30'd0, in1_ready, in0_ready}, 32'd0);
            step();
            chk("bp_hold_data",  {24'd0, out_data}, 32'hC0);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {30'd0, in1_ready, in0_ready}, 32'd1);
        step();
        chk("bp_next_data", {24'd0, out_data}, 32'h14);
        in0_valid = 1'b0;
        step();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_hold",  {24'd0, out_data}, 32'h14);
        chk("sb_count", got_q.size(), 32'd2);
        if (got_q.size() == 2) begin
            chk("sb_beat0", {24'd0, got_q[0]}, 32'hC0);
            chk("sb_beat1", {24'd0, got_q[1]}, 32'h14);
        end

        // ---------------- valid gap inside an in1 packet ----------------
        in0_valid = 1'b1; in0_data = 8'h30; in0_last = 1'b1;
        in1_valid = 1'b1; in1_data = 8'h21; in1_last = 1'b0;
        #1;
        chk("gap_grant", {30'd0, in1_ready, in0_ready}, 32'd2);
        step();
        chk("gap_data0", {24'd0, out_data}, 32'h21);
        chk("gap_sel0",  {31'd0, sel}, 32'd1);
        chk("gap_busy0", {31'd0, busy}, 32'd1);
        in1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("gap_in0_blocked", {31'd0, in0_ready}, 32'd0);
            step();
            chk("gap_busy", {31'd0, busy}, 32'd1);
            chk("gap_out_empty", {31'd0, out_valid}, 32'd0);
        end
        in1_valid = 1'b1; in1_data = 8'h22; in1_last = 1'b1;
        step();
        chk("gap_data1", {24'd0, out_data}, 32'h22);
        chk("gap_last1", {31'd0, out_last}, 32'd1);
        chk("gap_busy1", {31'd0, busy}, 32'd0);

        // ---------------- asynchronous reset inside an in0 packet ----------------
        in1_valid = 1'b0;
        in0_data  = 8'h40; in0_last = 1'b0;
        #1;
        chk("ar_grant", {30'd0, in1_ready, in0_ready}, 32'd1);
        step();
        chk("ar_locked", {31'd0, busy}, 32'd1);
        chk("ar_data",   {24'd0, out_data}, 32'h40);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid",   {31'd0, out_valid}, 32'd0);
        chk("ar_data0",   {24'd0, out_data}, 32'd0);
        chk("ar_busy",    {31'd0, busy}, 32'd0);
        chk("ar_readies", {30'd0, in1_ready, in0_ready}, 32'd0);
        step();
        rst_n = 1'b1;
        in0_data = 8'h50; in0_last = 1'b1;
        in1_valid = 1'b1; in1_data = 8'h60; in1_last = 1'b1;
        #1;
        chk("ar_restart_grant", {30'd0, in1_ready, in0_ready}, 32'd1);
        step();
        chk("ar_restart_data", {24'd0, out_data}, 32'h50);
        chk("ar_restart_sel",  {31'd0, sel}, 32'd0);
        chk("ar_restart_busy", {31'd0, busy}, 32'd0);
        chk("ar_next_grant", {30'd0, in1_ready, in0_ready}, 32'd2);
        step();
        chk("ar_next_data", {24'd0, out_data}, 32'h60);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
